coproc_scheduler: RTL and testbench

Command scheduler in front of the matrix coprocessor. It buffers operation requests (opcode, matrix size, tag) from the HPS-side control logic in a small FIFO and launches them on the coprocessor one at a time. After each launch it holds the operands stable, waits a fixed settle window, then samples the coprocessor's done flag under a timeout. Each launched or rejected command produces exactly one tagged status response.

---
 rtl/coproc_sched_pkg.sv | 23 ++
 rtl/coproc_scheduler_cmd_fifo.sv | 65 ++++++
 rtl/coproc_scheduler.sv | 168 ++++++++++++++++
 tb/tb_coproc_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_sched_pkg.sv
// Shared constants for the coprocessor command scheduler: opcode legality,
// response status codes, FSM state encoding and the queued command layout.
package coproc_sched_pkg;

    localparam logic [2:0] OPC_ILLEGAL = 3'd7;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] size;
        logic [3:0] tag;
    } cmd_t;

endpackage

// File: rtl/coproc_scheduler_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head word is read
// combinationally so the scheduler can decode it in the same cycle it pops.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/coproc_scheduler.sv
// Queues coprocessor commands, launches them one at a time, waits a settle
// window, then samples cop_done under a timeout and returns a tagged status.
module coproc_scheduler
    import coproc_sched_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [1:0]               cmd_size,
    input  logic [3:0]               cmd_tag,
    output logic [2:0]               cop_op_code,
    output logic [1:0]               cop_matrix_size,
    output logic                     cop_start,
    input  logic                     cop_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_tag,
    output logic [1:0]               rsp_status,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   queue_count
);
    localparam int         SW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [8:0]    fifo_head;
    cmd_t          head;
    cmd_t          cur_q, cur_d;
    logic [2:0]    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [7:0]    timer_q, timer_d;
    logic [2:0]    cop_op_q, cop_op_d;
    logic [1:0]    cop_size_q, cop_size_d;
    logic          cop_start_q, cop_start_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [3:0]    rsp_tag_q, rsp_tag_d;
    logic [1:0]    rsp_status_q, rsp_status_d;
    logic          busy_q, busy_d;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_opcode, cmd_size, cmd_tag}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (queue_count)
    );

    assign head      = cmd_t'(fifo_head);
    assign cmd_ready = !fifo_full;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        settle_d     = settle_q;
        timer_d      = timer_q;
        cop_op_d     = cop_op_q;
        cop_size_d   = cop_size_q;
        cop_start_d  = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_status_d = rsp_status_q;
        fifo_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = head;
                    if (head.opcode == OPC_ILLEGAL) begin
                        state_d      = S_REPORT;
                        rsp_valid_d  = 1'b1;
                        rsp_tag_d    = head.tag;
                        rsp_status_d = ST_ILLEGAL;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cop_op_d    = cur_q.opcode;
                cop_size_d  = cur_q.size;
                cop_start_d = 1'b1;
                settle_d    = SW'(SETTLE_CYCLES - 1);
                state_d     = S_SETTLE;
            end
            // cop_done is ignored here: it may still reflect the previous operation.
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            S_WAIT: begin
                if (cop_done) begin
                    state_d      = S_REPORT;
                    rsp_valid_d  = 1'b1;
                    rsp_tag_d    = cur_q.tag;
                    rsp_status_d = ST_OK;
                end else if (timer_q == TIMEOUT_W) begin
                    state_d      = S_REPORT;
                    rsp_valid_d  = 1'b1;
                    rsp_tag_d    = cur_q.tag;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_REPORT: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            settle_q     <= '0;
            timer_q      <= '0;
            cop_op_q     <= '0;
            cop_size_q   <= '0;
            cop_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_status_q <= ST_OK;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            settle_q     <= settle_d;
            timer_q      <= timer_d;
            cop_op_q     <= cop_op_d;
            cop_size_q   <= cop_size_d;
            cop_start_q  <= cop_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_status_q <= rsp_status_d;
            busy_q       <= busy_d;
        end
    end

    assign cop_op_code     = cop_op_q;
    assign cop_matrix_size = cop_size_q;
    assign cop_start       = cop_start_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_tag         = rsp_tag_q;
    assign rsp_status      = rsp_status_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_coproc_scheduler.sv
// Directed bench for coproc_scheduler with default parameters; inputs change
// and outputs are sampled on the falling edge.
module tb_coproc_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [1:0] cmd_size;
    logic [3:0] cmd_tag;
    logic [2:0] cop_op_code;
    logic [1:0] cop_matrix_size;
    logic       cop_start;
    logic       cop_done;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_tag;
    logic [1:0] rsp_status;
    logic       busy;
    logic [2:0] queue_count;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    coproc_scheduler #(.DEPTH(4), .SETTLE_CYCLES(2), .TIMEOUT(255)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_opcode      (cmd_opcode),
        .cmd_size        (cmd_size),
        .cmd_tag         (cmd_tag),
        .cop_op_code     (cop_op_code),
        .cop_matrix_size (cop_matrix_size),
        .cop_start       (cop_start),
        .cop_done        (cop_done),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tag         (rsp_tag),
        .rsp_status      (rsp_status),
        .busy            (busy),
        .queue_count     (queue_count)
    );

    always #5 clk = ~clk;

    // Counts launch pulses by sampling the registered strobe at the active edge.
    always @(posedge clk) if (cop_start === 1'b1) start_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] tg);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_size   = sz;
        cmd_tag    = tg;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cop_op"},    32'(cop_op_code), 0);
        check({pfx, "_cop_size"},  32'(cop_matrix_size), 0);
        check({pfx, "_cop_start"}, 32'(cop_start), 0);
        check({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({pfx, "_rsp_tag"},   32'(rsp_tag), 0);
        check({pfx, "_rsp_status"},32'(rsp_status), 0);
        check({pfx, "_busy"},      32'(busy), 0);
        check({pfx, "_qcount"},    32'(queue_count), 0);
    endtask

    initial begin
        int s0;
        int busy_err, rv_err, hold_err, rsp_seen, n;
        logic acc;
        logic [3:0] got_tag [6];
        logic [1:0] got_st  [6];
        logic [3:0] exp_tag [6];

        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_size = '0; cmd_tag = '0;
        cop_done = 1'b1; rsp_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Legal command, cop_done already high: rsp_valid five edges after acceptance.
        drive_cmd(3'd2, 2'd3, 4'd5);
        tick();                                   // edge N: accepted
        cmd_valid = 1'b0;
        check("t1_qcount_after_push", 32'(queue_count), 1);
        tick();                                   // N+1: pop
        check("t1_qcount_after_pop", 32'(queue_count), 0);
        check("t1_busy", 32'(busy), 1);
        check("t1_no_start_yet", 32'(cop_start), 0);
        tick();                                   // N+2: launch
        check("t1_start", 32'(cop_start), 1);
        check("t1_cop_op", 32'(cop_op_code), 2);
        check("t1_cop_size", 32'(cop_matrix_size), 3);
        tick();                                   // N+3
        check("t1_start_one_cycle", 32'(cop_start), 0);
        check("t1_rsp_early3", 32'(rsp_valid), 0);
        tick();                                   // N+4
        check("t1_rsp_early4", 32'(rsp_valid), 0);
        tick();                                   // N+5
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_rsp_tag", 32'(rsp_tag), 5);
        check("t1_rsp_status", 32'(rsp_status), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_rsp_cleared", 32'(rsp_valid), 0);
        check("t1_idle", 32'(busy), 0);

        // Illegal opcode: reported one edge after the pop, no launch.
        s0 = start_cnt;
        drive_cmd(3'd7, 2'd1, 4'd9);
        tick();                                   // N: accepted
        cmd_valid = 1'b0;
        tick();                                   // N+1: pop and report
        check("t2_rsp_valid", 32'(rsp_valid), 1);
        check("t2_rsp_status", 32'(rsp_status), 2);
        check("t2_rsp_tag", 32'(rsp_tag), 9);
        check("t2_cop_op_kept", 32'(cop_op_code), 2);
        check("t2_cop_size_kept", 32'(cop_matrix_size), 3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick(); tick();
        check("t2_no_start", 32'(start_cnt), 32'(s0));

        // Timeout: WAIT entered at N+4, response 256 cycles later at N+260.
        cop_done = 1'b0;
        drive_cmd(3'd1, 2'd0, 4'd3);
        tick();                                   // N
        cmd_valid = 1'b0;
        busy_err = 0; rv_err = 0;
        for (int i = 1; i <= 259; i++) begin
            tick();
            if (busy !== 1'b1) busy_err++;
            if (rsp_valid !== 1'b0) rv_err++;
        end
        check("t3_busy_throughout", 32'(busy_err), 0);
        check("t3_no_early_rsp", 32'(rv_err), 0);
        tick();                                   // N+260
        check("t3_rsp_valid", 32'(rsp_valid), 1);
        check("t3_rsp_status", 32'(rsp_status), 1);
        check("t3_rsp_tag", 32'(rsp_tag), 3);
        check("t3_busy", 32'(busy), 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Fill the FIFO while one command sits in WAIT, then drain in order.
        drive_cmd(3'd0, 2'd1, 4'hA);
        tick();                                   // N
        cmd_valid = 1'b0;
        tick(); tick(); tick(); tick();           // N+4: in WAIT
        check("t4_qcount_empty", 32'(queue_count), 0);
        drive_cmd(3'd3, 2'd0, 4'd1); tick();
        check("t4_qcount1", 32'(queue_count), 1);
        drive_cmd(3'd4, 2'd1, 4'd2); tick();
        check("t4_qcount2", 32'(queue_count), 2);
        drive_cmd(3'd5, 2'd2, 4'd3); tick();
        check("t4_qcount3", 32'(queue_count), 3);
        check("t4_ready_at3", 32'(cmd_ready), 1);
        drive_cmd(3'd6, 2'd3, 4'd4); tick();
        check("t4_qcount4", 32'(queue_count), 4);
        check("t4_ready_full", 32'(cmd_ready), 0);
        drive_cmd(3'd1, 2'd1, 4'd5); tick();      // refused: FIFO full
        check("t4_qcount_held", 32'(queue_count), 4);
        check("t4_ready_still_low", 32'(cmd_ready), 0);
        cop_done  = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n < 6; i++) begin
            if (rsp_valid === 1'b1) begin
                got_tag[n] = rsp_tag;
                got_st[n]  = rsp_status;
                n++;
            end
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        check("t4_rsp_count", 32'(n), 6);
        check("t4_tag5_accepted", 32'(cmd_valid), 0);
        exp_tag[0] = 4'hA; exp_tag[1] = 4'd1; exp_tag[2] = 4'd2;
        exp_tag[3] = 4'd3; exp_tag[4] = 4'd4; exp_tag[5] = 4'd5;
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                check($sformatf("t4_tag%0d", i), 32'(got_tag[i]), 32'(exp_tag[i]));
                check($sformatf("t4_status%0d", i), 32'(got_st[i]), 0);
            end
        end
        tick();

        // Response back-pressure: outputs hold and the queued command waits.
        drive_cmd(3'd2, 2'd2, 4'd6); tick();      // N
        drive_cmd(3'd4, 2'd1, 4'd7); tick();      // N+1
        cmd_valid = 1'b0;
        tick(); tick(); tick(); tick();           // N+5
        check("t5_rsp_valid", 32'(rsp_valid), 1);
        check("t5_rsp_tag", 32'(rsp_tag), 6);
        check("t5_qcount", 32'(queue_count), 1);
        s0 = start_cnt;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd6 || rsp_status !== 2'b00) hold_err++;
            if (queue_count !== 3'd1) hold_err++;
        end
        check("t5_hold_stable", 32'(hold_err), 0);
        check("t5_no_launch", 32'(start_cnt), 32'(s0));
        rsp_ready = 1'b1;
        tick();                                   // H: handshake
        rsp_ready = 1'b0;
        check("t5_rsp_dropped", 32'(rsp_valid), 0);
        check("t5_bubble_no_start", 32'(cop_start), 0);
        tick();                                   // H+1: pop
        check("t5_pop_qcount", 32'(queue_count), 0);
        tick();                                   // H+2: launch
        check("t5_start2", 32'(cop_start), 1);
        check("t5_cop_op2", 32'(cop_op_code), 4);
        check("t5_cop_size2", 32'(cop_matrix_size), 1);
        tick(); tick(); tick();                   // H+5
        check("t5_rsp2_valid", 32'(rsp_valid), 1);
        check("t5_rsp2_tag", 32'(rsp_tag), 7);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during SETTLE with two commands queued.
        drive_cmd(3'd1, 2'd2, 4'd8); tick();      // N
        drive_cmd(3'd2, 2'd0, 4'd9); tick();      // N+1: pop tag 8
        drive_cmd(3'd3, 2'd1, 4'd10); tick();     // N+2: launch, SETTLE next
        cmd_valid = 1'b0;
        check("t6_start_before_rst", 32'(cop_start), 1);
        check("t6_cop_op_before_rst", 32'(cop_op_code), 1);
        check("t6_qcount_before_rst", 32'(queue_count), 2);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) rsp_seen++;
        end
        check("t6_no_response", 32'(rsp_seen), 0);
        check("t6_qcount_final", 32'(queue_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence finished");
        $fatal(1, "watchdog");
    end

endmodule
